// File: rtl/perf_measure_ctrl.sv
// Sequencer that gates an external cycle counter between start/stop triggers.
// Host commands in, counter en/clr out, captured result/wraps/state out.
module perf_measure_ctrl #(
  parameter int NBITS = 32,
  parameter int NTRIG = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SELW-1:0]  cmd_start_sel,
  input  logic [SELW-1:0]  cmd_stop_sel,
  input  logic [NTRIG-1:0] trig,
  input  logic [NBITS-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [NBITS-1:0] result,
  output logic [7:0]       wraps,
  output logic [2:0]       state_o,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARMD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_ARM = 2'd1;
  localparam logic [1:0] OP_ABT = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [SELW-1:0] start_sel;
  logic [SELW-1:0] stop_sel;
  logic [7:0]      acc;

  logic accept;
  logic quiet;
  logic busy;
  logic arm_ok;
  logic arm_bad;
  logic clr_ok;
  logic clr_bad;
  logic abort;
  logic start_hit;
  logic stop_hit;

  assign accept  = cmd_valid && cmd_ready;
  assign quiet   = (state == S_IDLE) || (state == S_DONE);
  assign busy    = (state == S_ARMD) || (state == S_RUN);
  assign arm_ok  = accept && (cmd_op == OP_ARM) && quiet;
  assign arm_bad = accept && (cmd_op == OP_ARM) && busy;
  assign clr_ok  = accept && (cmd_op == OP_CLR) && quiet;
  assign clr_bad = accept && (cmd_op == OP_CLR) && busy;
  assign abort   = accept && (cmd_op == OP_ABT);

  assign start_hit = trig[start_sel];
  assign stop_hit  = trig[stop_sel];

  // Counter is cleared with the controller and again on every legal ARM,
  // so it reads zero in ARMED and counts only RUNNING cycles.
  assign cnt_clr = reset || arm_ok;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (arm_ok)               state_nx = S_ARMD;
        else if (clr_ok || abort) state_nx = S_IDLE;
      end
      S_ARMD: begin
        // Abort has priority over a coincident trigger.
        if (abort)          state_nx = S_IDLE;
        else if (start_hit) state_nx = S_RUN;
      end
      S_RUN: begin
        if (abort)         state_nx = S_IDLE;
        else if (stop_hit) state_nx = S_CAPT;
      end
      S_CAPT:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state != S_CAPT);
    cnt_en    = (state == S_RUN);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_sel <= '0;
      stop_sel  <= '0;
      acc       <= '0;
      result    <= '0;
      wraps     <= '0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= arm_bad || clr_bad;
      if (arm_ok) begin
        start_sel <= cmd_start_sel;
        stop_sel  <= cmd_stop_sel;
        acc       <= '0;
      end
      // All-ones now means the counter wraps on this edge.
      if (state == S_RUN && (&count_in) && acc != 8'hff)
        acc <= acc + 8'd1;
      if (state == S_CAPT) begin
        result <= count_in;
        wraps  <= acc;
      end
      if (clr_ok) begin
        result <= '0;
        wraps  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_perf_measure_ctrl.sv
// Bench for perf_measure_ctrl with an 8-bit counter model and run-level
// reference: each run of n cycles yields n mod 256 and n/256 rollovers.
module tb_perf_measure_ctrl;

  localparam int NBITS = 8;

  logic             clk = 0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_start_sel;
  logic [1:0]       cmd_stop_sel;
  logic [3:0]       trig;
  logic [NBITS-1:0] count;
  logic             cnt_en;
  logic             cnt_clr;
  logic [NBITS-1:0] result;
  logic [7:0]       wraps;
  logic [2:0]       state_o;
  logic             done;
  logic             cmd_err;

  int nchk  = 0;
  int nfail = 0;
  int en_cyc = 0;
  int exp_res = 0;
  int exp_wr  = 0;

  perf_measure_ctrl #(.NBITS(NBITS), .NTRIG(4), .SELW(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_start_sel(cmd_start_sel), .cmd_stop_sel(cmd_stop_sel),
    .trig(trig), .count_in(count),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .result(result), .wraps(wraps), .state_o(state_o),
    .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr)     count <= '0;
    else if (cnt_en) count <= count + 1'b1;
  end

  always @(negedge clk) if (cnt_en) en_cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input int s, input int p);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_start_sel = 2'(s);
    cmd_stop_sel  = 2'(p);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic set_exp(input int n);
    exp_res = n % 256;
    exp_wr  = (n / 256 > 255) ? 255 : n / 256;
  endtask

  task automatic pulse(input int idx);
    trig[idx] = 1'b1;
    tick();
    trig = '0;
  endtask

  task automatic run(input int s, input int p, input int dly, input int n,
                     input bit ab, input int ab_at);
    int e0;
    cmd(2'd1, s, p);
    chk("arm_state", state_o, 1);
    chk("arm_count", count, 0);
    repeat (dly) tick();
    e0 = en_cyc;
    pulse(s);
    chk("run_state", state_o, 2);
    if (ab) begin
      repeat (ab_at - 1) tick();
      cmd(2'd2, 0, 0);
      chk("abort_state", state_o, 0);
      chk("abort_en", cnt_en, 0);
      chk("abort_result", result, exp_res);
      chk("abort_wraps", wraps, exp_wr);
      chk("abort_encyc", en_cyc - e0, ab_at);
    end else begin
      repeat (n - 1) tick();
      pulse(p);
      chk("capt_state", state_o, 3);
      tick();
      set_exp(n);
      chk("done", done, 1);
      chk("result", result, exp_res);
      chk("wraps", wraps, exp_wr);
      chk("encyc", en_cyc - e0, n);
    end
  endtask

  initial begin
    int e0;
    reset = 1; cmd_valid = 0; cmd_op = 0;
    cmd_start_sel = 0; cmd_stop_sel = 0; trig = '0;
    #1;
    chk("rst_clr", cnt_clr, 1);
    tick(); tick();
    chk("rst_state", state_o, 0);
    chk("rst_result", result, 0);
    chk("rst_wraps", wraps, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 0;
    tick();
    chk("idle_clr", cnt_clr, 0);

    // basic 100-cycle run, start at 10 cycles after ARM
    run(0, 1, 9, 100, 0, 0);
    // rollover
    run(1, 3, 2, 600, 0, 0);

    // same trigger, level held
    cmd(2'd1, 2, 2);
    trig[2] = 1'b1;
    tick(); tick();
    chk("same_capt", state_o, 3);
    tick();
    trig = '0;
    chk("same_held", result, 1);
    set_exp(1);
    run(2, 2, 3, 7, 0, 0);

    // abort mid-run keeps previous result
    run(0, 1, 0, 100, 0, 0);
    run(0, 1, 2, 0, 1, 50);
    // abort coincident with stop trigger
    cmd(2'd1, 1, 3);
    pulse(1);
    repeat (5) tick();
    trig[3] = 1'b1;
    cmd(2'd2, 0, 0);
    trig = '0;
    chk("abt_stop_state", state_o, 0);
    chk("abt_stop_result", result, exp_res);

    // illegal CLEAR while ARMED
    cmd(2'd1, 0, 1);
    cmd(2'd3, 0, 0);
    chk("clr_armd_err", cmd_err, 1);
    chk("clr_armd_state", state_o, 1);
    chk("clr_armd_res", result, exp_res);
    tick();
    chk("err_pulse", cmd_err, 0);
    // illegal ARM while RUNNING; run completes; CLEAR held through CAPTURE
    e0 = en_cyc;
    pulse(0);
    repeat (9) tick();
    cmd(2'd1, 3, 3);
    chk("arm_run_err", cmd_err, 1);
    chk("arm_run_state", state_o, 2);
    tick();
    chk("arm_run_err_lo", cmd_err, 0);
    repeat (28) tick();
    pulse(1);
    set_exp(40);
    chk("ill_encyc", en_cyc - e0, 40);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    #1;
    chk("capt_ready", cmd_ready, 0);
    tick();
    chk("capt_hold_st", state_o, 4);
    chk("ill_result", result, exp_res);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    exp_res = 0; exp_wr = 0;
    chk("clr_state", state_o, 0);
    chk("clr_result", result, 0);
    chk("clr_wraps", wraps, 0);

    // reset mid-run
    run(2, 0, 1, 300, 0, 0);
    cmd(2'd1, 1, 2);
    pulse(1);
    repeat (30) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_clr", cnt_clr, 1);
    tick();
    reset = 1'b0;
    exp_res = 0; exp_wr = 0;
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_wraps", wraps, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_count", count, 0);
    run(1, 2, 0, 77, 0, 0);

    // randomized runs, some aborted
    for (int k = 0; k < 12; k++) begin
      int s, p, d, n, at;
      bit ab;
      s  = $urandom_range(0, 3);
      p  = $urandom_range(0, 3);
      d  = $urandom_range(0, 5);
      n  = $urandom_range(1, 700);
      ab = ($urandom_range(0, 3) == 0);
      at = $urandom_range(1, n);
      run(s, p, d, n, ab, at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/perf_measure_ctrl.md
Name: perf_measure_ctrl

Overview:
- Sequencer for an external enable-gated cycle counter used in performance measurement.
- Software arms a measurement and selects start and stop trigger lines. The block then gates the counter's enable from the start trigger to the stop trigger.
- At the end of a run it captures the count and the number of counter rollovers into result registers.
- Sits between the host command/register interface and one counter instance (counter has `clk`, `reset`, `en`, `count`; reset is synchronous).

Parameters:
- NBITS, 32, width of the external counter and of `result`.
- NTRIG, 4, number of trigger inputs.
- SELW, 2, width of the trigger select fields (clog2 of NTRIG).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command strobe.
- cmd_ready, out, 1, command accepted when cmd_valid && cmd_ready.
- cmd_op, in, 2, 0=NOP, 1=ARM, 2=ABORT, 3=CLEAR.
- cmd_start_sel, in, SELW, start trigger index; latched on ARM.
- cmd_stop_sel, in, SELW, stop trigger index; latched on ARM.
- trig, in, NTRIG, trigger lines; each is a level sampled every clock.
- count_in, in, NBITS, count output of the external counter.
- cnt_en, out, 1, drives counter en.
- cnt_clr, out, 1, drives counter reset.
- result, out, NBITS, captured cycle count.
- wraps, out, 8, captured rollover count; saturates at 255.
- state_o, out, 3, current state encoding.
- done, out, 1, high in DONE.
- cmd_err, out, 1, one-cycle pulse on an illegal command.

Behaviour:
- Reset values: state IDLE; result 0; wraps 0; internal wrap accumulator 0; latched selects 0; cnt_en 0; cnt_clr 1 while reset is high (counter is cleared together with the controller); done 0; cmd_err 0.
- States and encodings: IDLE=0, ARMED=1, RUNNING=2, CAPTURE=3, DONE=4.
- cmd_ready: 0 in CAPTURE, 1 in all other states.
- cnt_en = (state==RUNNING), combinational from state.
- cnt_clr = reset, or ARM accepted this cycle (combinational pulse). The counter therefore reads 0 on the cycle after ARM.
- IDLE or DONE + ARM:
  - Latch both selects.
  - Clear the wrap accumulator.
  - Next state ARMED.
  - result and wraps keep their previous values until the next capture.
- ARMED:
  - trig[start_sel]==1 on a clock edge → next state RUNNING.
  - Otherwise stay in ARMED.
- RUNNING:
  - The counter increments every cycle in RUNNING.
  - If count_in == all-ones, the accumulator increments (saturating at 255), because the counter wraps to 0 on that edge.
  - trig[stop_sel]==1 → next state CAPTURE. The counter also increments on that cycle.
  - Stop is only sampled in RUNNING. If start_sel==stop_sel, a level held high stops on the first RUNNING cycle, giving result=1.
- Count definition: start sampled at edge t and stop sampled at edge u → result = u - t, modulo 2^NBITS.
- CAPTURE (one cycle):
  - result <= count_in.
  - wraps <= accumulator.
  - Next state DONE.
- DONE: done=1; hold until ARM, CLEAR or ABORT.
- ABORT:
  - From ARMED or RUNNING → IDLE; no capture; result and wraps unchanged; cnt_en drops on the next cycle.
  - Accepted in IDLE and DONE (→ IDLE) with no other effect.
- CLEAR:
  - Only legal in IDLE and DONE: result <= 0, wraps <= 0, next state IDLE.
- Illegal commands pulse cmd_err for one cycle and leave state unchanged:
  - ARM while in ARMED or RUNNING.
  - CLEAR while in ARMED or RUNNING.
- Simultaneous events:
  - ABORT in the same cycle as a start or stop trigger: ABORT wins.
  - cmd_valid in CAPTURE is not accepted; the host must hold it.
- Reset mid-run: reset returns to IDLE immediately, clears the counter via cnt_clr, and zeroes result and wraps.
- NOP: no effect.

Test Plan:
- Basic run, start_sel=0, stop_sel=1: ARM; trig[0] pulse at edge 10; trig[1] pulse at edge 110 → cnt_en high exactly 100 cycles; result=100; wraps=0; done=1 two cycles after the stop edge.
- Rollover, NBITS=8: ARM; start, then stop 600 cycles later → result=600 mod 256=88; wraps=2.
- Same trigger, start_sel=stop_sel=2: trig[2] held high → result=1. Repeat with a single-cycle pulse, then a second pulse 7 cycles later → result=7.
- ABORT during RUNNING after 50 cycles, with previous result=100 → state IDLE; result stays 100; cnt_en low next cycle. ABORT in the same cycle as the stop trigger → also no capture.
- Illegal commands: ARM while RUNNING → cmd_err pulse and the run completes normally. CLEAR in DONE → result=0, wraps=0, state IDLE. cmd_valid in CAPTURE → cmd_ready=0 and the command is accepted one cycle later.
- Reset asserted mid-RUNNING for 1 cycle → cnt_clr=1, state IDLE, result=0, done=0; a subsequent ARM/start/stop run measures correctly.
